// File: rtl/bk_subtractor_24bit.sv
// 24-bit pipelined subtractor: diff = a - b - bin, computed as a + ~b + ~bin
// through a Brent-Kung prefix carry network split over three register stages.
// S1 holds bitwise propagate/generate, S2 the prefix up-sweep, S3 the results.

// Per-bit propagate/generate for a + ~b.
module bk_pg_cell (
    input  logic a_i,
    input  logic b_i,
    output logic p_o,
    output logic g_o
);
    assign p_o = a_i ^ ~b_i;
    assign g_o = a_i & ~b_i;
endmodule

module bk_subtractor_24bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] diff,
    output logic        bout,
    output logic        ovf,
    output logic        zero
);
    localparam int W      = 24;
    localparam int STAGES = 3;
    localparam int LEVELS = 4;   // spans 1,2,4,8 combine into 2/4/8/16-bit groups

    // Carry-network state travelling down the pipe. p is the propagate used by
    // the prefix tree (bit 0 has the carry-in folded in), p_raw the unmodified
    // propagate needed for the final sum XOR.
    typedef struct packed {
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic [W-1:0] p_raw;
        logic         cin;
        logic         a_msb;
        logic         b_msb;
    } stage_t;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
        logic         zero;
    } res_t;

    logic [STAGES:1] vld_pipe_q, vld_pipe_d;
    stage_t          s1_q, s1_d, s2_q, s2_d;
    res_t            res_q, res_d;
    logic            advance;
    logic [W-1:0]    pg_p, pg_g;
    logic [W-1:0]    up_g, up_p;
    logic [W-1:0]    dn_g;
    logic [W-1:0]    carry, sum;
    logic            unused_p;

    // The whole pipe moves together; it only freezes when a result is stuck.
    assign advance  = !vld_pipe_q[STAGES] || out_ready;
    assign in_ready = advance && !rst;

    assign out_valid = vld_pipe_q[STAGES];
    assign diff      = res_q.diff;
    assign bout      = res_q.bout;
    assign ovf       = res_q.ovf;
    assign zero      = res_q.zero;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_pg
            bk_pg_cell u_pg (
                .a_i (a[gi]),
                .b_i (b[gi]),
                .p_o (pg_p[gi]),
                .g_o (pg_g[gi])
            );
        end
    endgenerate

    // S1 load: bitwise p/g, with the carry-in (~bin) absorbed into bit 0 so the
    // tree only ever sees pure generate at the bottom.
    always_comb begin
        s1_d = s1_q;
        if (advance) begin
            s1_d.p_raw = pg_p;
            s1_d.p     = pg_p;
            s1_d.g     = pg_g;
            s1_d.g[0]  = pg_g[0] | (pg_p[0] & ~bin);
            s1_d.p[0]  = 1'b0;
            s1_d.cin   = ~bin;
            s1_d.a_msb = a[W-1];
            s1_d.b_msb = b[W-1];
        end
    end

    // Up-sweep: at span s, position i with (i+1) a multiple of 2s absorbs the
    // group ending at i-s. Positions read at a level are never written at it.
    always_comb begin
        int s;
        int j;
        s    = 1;
        j    = 0;
        up_g = s1_q.g;
        up_p = s1_q.p;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            s = 1 << lvl;
            for (int i = 0; i < W; i++) begin
                j = (i >= s) ? i - s : 0;
                if (((i + 1) % (2 * s)) == 0) begin
                    up_g[i] = up_g[i] | (up_p[i] & up_g[j]);
                    up_p[i] = up_p[i] & up_p[j];
                end
            end
        end
    end

    // S2 load: up-sweep groups plus the side-band bits needed at the end.
    always_comb begin
        s2_d = s2_q;
        if (advance) begin
            s2_d   = s1_q;
            s2_d.g = up_g;
            s2_d.p = up_p;
        end
    end

    // Down-sweep: fill in every remaining prefix from the widest span down.
    // Only generate is needed afterwards, so propagate is not updated here.
    always_comb begin
        int s;
        int j;
        s    = 1;
        j    = 0;
        dn_g = s2_q.g;
        for (int lvl = LEVELS - 1; lvl >= 0; lvl--) begin
            s = 1 << lvl;
            for (int i = 0; i < W; i++) begin
                j = (i >= s) ? i - s : 0;
                if ((((i + 1) % (2 * s)) == s) && ((i + 1) > (2 * s))) begin
                    dn_g[i] = dn_g[i] | (s2_q.p[i] & dn_g[j]);
                end
            end
        end
    end

    // Carry into bit i is the prefix generate of bits i-1..0 (cin into bit 0).
    assign carry = {dn_g[W-2:0], s2_q.cin};
    assign sum   = s2_q.p_raw ^ carry;

    // Prefix positions already complete after the up-sweep are never re-read.
    assign unused_p = &{s2_q.p[15], s2_q.p[7], s2_q.p[3], s2_q.p[1], s2_q.p[0]};

    // Output registers only take a new value when a real operand leaves S2.
    always_comb begin
        res_d = res_q;
        if (vld_pipe_q[2] && advance) begin
            res_d.diff = sum;
            res_d.bout = ~dn_g[W-1];
            res_d.ovf  = (s2_q.a_msb != s2_q.b_msb) && (sum[W-1] != s2_q.a_msb);
            res_d.zero = ~|sum;
        end
    end

    // Valid bits shift with the data; bubbles travel as zeros.
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        if (advance) begin
            vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_valid};
        end
    end

    // State update; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            res_q      <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            res_q      <= res_d;
        end
    end
endmodule

// File: tb/tb_bk_subtractor_24bit.sv
// Self-checking bench for bk_subtractor_24bit: directed vector table with
// latency checks, stall, mid-flight reset and a random streaming run.
module tb_bk_subtractor_24bit;
    typedef struct packed {
        logic [23:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct packed {
        logic [23:0] a;
        logic [23:0] b;
        logic        bin;
        res_t        exp;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] a;
    logic [23:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    int   tests = 0;
    int   fails = 0;
    int   n_out = 0;
    bit   mon_en = 0;
    res_t expq[$];
    bit   hold_pend = 0;
    res_t hold_val;
    vec_t tbl[12];

    bk_subtractor_24bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic res_t model(input logic [23:0] x, input logic [23:0] y, input logic c);
        res_t        r;
        logic [24:0] t;
        int          sd;
        t      = {1'b0, x} - {1'b0, y} - {24'd0, c};
        r.diff = t[23:0];
        r.bout = t[24];
        sd     = int'($signed(x)) - int'($signed(y)) - int'(c);
        r.ovf  = (sd > 8388607) || (sd < -8388608);
        r.zero = (t[23:0] == 24'd0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand and hold it until the DUT takes it.
    task automatic send(input logic [23:0] x, input logic [23:0] y, input logic c);
        bit acc;
        a = x; b = y; bin = c; in_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 40 && expq.size() != 0; k++) tick();
        chk(nm, 32'(expq.size()), 32'd0);
    endtask

    // Scoreboard: records transfers at the negedge before the edge they happen.
    always @(negedge clk) begin
        res_t cur;
        res_t e;
        if (mon_en) begin
            cur = {diff, bout, ovf, zero};
            if (hold_pend && out_valid) chk("stall_hold", 32'(cur), 32'(hold_val));
            if (rst) begin
                expq.delete();
                hold_pend = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    n_out++;
                    if (expq.size() == 0) begin
                        chk("unexpected_output", 32'(cur), 32'hFFFF_FFFF);
                    end else begin
                        e = expq.pop_front();
                        chk("stream_result", 32'(cur), 32'(e));
                    end
                end
                if (in_valid && in_ready) expq.push_back(model(a, b, bin));
                hold_pend = out_valid && !out_ready;
                hold_val  = cur;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   n0;
        res_t got;

        tbl[0]  = {24'h000005, 24'h000003, 1'b0, 24'h000002, 3'b000};
        tbl[1]  = {24'h000000, 24'h000001, 1'b0, 24'hFFFFFF, 3'b100};
        tbl[2]  = {24'h000007, 24'h000006, 1'b1, 24'h000000, 3'b001};
        tbl[3]  = {24'h800000, 24'h000001, 1'b0, 24'h7FFFFF, 3'b010};
        tbl[4]  = {24'h7FFFFF, 24'hFFFFFF, 1'b0, 24'h800000, 3'b110};
        tbl[5]  = {24'h000000, 24'h000000, 1'b1, 24'hFFFFFF, 3'b100};
        tbl[6]  = {24'h000000, 24'h000000, 1'b0, 24'h000000, 3'b001};
        tbl[7]  = {24'hFFFFFF, 24'hFFFFFF, 1'b1, 24'hFFFFFF, 3'b100};
        tbl[8]  = {24'h123456, 24'h012345, 1'b0, 24'h111111, 3'b000};
        tbl[9]  = {24'h000000, 24'hFFFFFF, 1'b0, 24'h000001, 3'b100};
        tbl[10] = {24'h800000, 24'h7FFFFF, 1'b1, 24'h000000, 3'b011};
        tbl[11] = {24'hABCDEF, 24'hABCDEE, 1'b1, 24'h000000, 3'b001};

        // Reset with in_valid high: must be ignored, outputs cleared.
        rst = 1'b1; in_valid = 1'b1; a = 24'h00000A; b = 24'h000001; bin = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_outputs", 32'({diff, bout, ovf, zero}), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        tick(); tick(); tick();
        chk("reset_no_output", 32'(out_valid), 32'd0);

        // Directed table, one operand at a time, with latency check.
        for (int i = 0; i < 12; i++) begin
            a = tbl[i].a; b = tbl[i].b; bin = tbl[i].bin; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 8) begin
                tick();
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            got = {diff, bout, ovf, zero};
            chk($sformatf("vec%0d_result", i), 32'(got), 32'(tbl[i].exp));
            tick();
        end

        // Stall: 4 back-to-back operands, out_ready low 2 cycles after out_valid.
        mon_en = 1'b1;
        n0 = n_out;
        fork
            begin
                send(24'h000010, 24'h000001, 1'b0);
                send(24'h000020, 24'h000002, 1'b0);
                send(24'h000030, 24'h000003, 1'b1);
                send(24'h000040, 24'h000050, 1'b0);
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 20 && !out_valid; k++) tick();
                chk("stall_out_valid", 32'(out_valid), 32'd1);
                out_ready = 1'b0;
                #1;
                chk("stall_in_ready_c1", 32'(in_ready), 32'd0);
                tick();
                chk("stall_in_ready_c2", 32'(in_ready), 32'd0);
                tick();
                out_ready = 1'b1;
            end
        join
        drain("stall_drain");
        chk("stall_count", 32'(n_out - n0), 32'd4);

        // Reset with two operands in flight plus one offered during reset.
        n0 = n_out;
        send(24'h0000AA, 24'h000011, 1'b0);
        send(24'h0000BB, 24'h000022, 1'b0);
        a = 24'h0000CC; b = 24'h000033; in_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 8; k++) tick();
        chk("midrst_no_results", 32'(n_out - n0), 32'd0);

        // Random stream with random bubbles and backpressure.
        n0 = n_out;
        for (int k = 0; k < 10000; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 24'($urandom);
            b         = 24'($urandom);
            bin       = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain("random_drain");
        if (n_out - n0 < 1000) chk("random_volume", 32'(n_out - n0), 32'd1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
